dsp_accum_dump_round_sat: RTL and testbench
===========================================

Name: dsp_accum_dump_round_sat

Overview:
- Downstream stage of the signed 20x18 multiply-accumulate DSP with unregistered 38-bit output.
- Counts ACC_LEN accumulation steps from the MAC, captures the accumulator and issues a one-cycle clear request back to the MAC.
- Rounds, arithmetic-shifts and saturates the captured value to OUT_W bits, then presents it on a valid/ready output through a small FIFO.

Parameters:
IN_W, 38, accumulator input width (MAC P width)
OUT_W, 16, output sample width
SHIFT, 12, right-shift applied before saturation (0 allowed: no rounding)
ACC_LEN, 8, accumulation steps per dump (>=1)
FIFO_DEPTH, 2, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
p_i  in  IN_W  signed accumulator value from MAC P
p_valid_i  in  1  p_i holds a freshly updated accumulation this cycle
soft_clear_i  in  1  sync abort: drop current frame, count to 0, pipeline emptied
acc_clear_o  out  1  one-cycle request to clear MAC accumulator
out_data_o  out  OUT_W  signed rounded/saturated result (FIFO head)
out_sat_o  out  1  head entry was saturated
out_valid_o  out  1  FIFO non-empty
out_ready_i  in  1  consumer accepts head when out_valid_o=1
overflow_o  out  1  sticky: a result was dropped because FIFO was full
clr_ovf_i  in  1  sync clear of overflow_o
count_o  out  $clog2(ACC_LEN+1)  steps accumulated in current frame

Behaviour:
- Reset (reset=0, async): state=ACCUM, count=0, stage-1 empty, FIFO empty. acc_clear_o=0, out_valid_o=0, out_data_o=0, out_sat_o=0, overflow_o=0, count_o=0.
- FSM has two states, ACCUM and CLEAR.
- ACCUM: each p_valid_i=1 increments count.
  - When p_valid_i=1 and count==ACC_LEN-1 (edge E): p_i is captured into stage 1, count->0, state->CLEAR.
- CLEAR: acc_clear_o=1 for exactly this one cycle. p_valid_i is ignored (MAC is being cleared). Next state is ACCUM.
- Stage 1 (edge E): r = sign-extended p_i to IN_W+1 bits, plus 2^(SHIFT-1) when SHIFT>0 (round half up). Then r is arithmetic-shifted right by SHIFT.
- Stage 2 (edge E+1): saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set the sat flag if clamped. Push {data, sat} into the FIFO.
- out_valid_o is high from the cycle after E+1, i.e. 2-cycle capture-to-valid latency.
- FIFO: pop when out_valid_o & out_ready_i.
  - A push while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the new result is dropped, overflow_o is set, and the FIFO is unchanged.
  - Push and pop on an empty FIFO is not bypassed: data appears the next cycle.
- out_data_o and out_sat_o hold the head entry. When the FIFO is empty they hold their last value; after reset they are 0.
- overflow_o stays sticky until clr_ovf_i=1. If a set and clr_ovf_i occur in the same cycle, set wins.
- soft_clear_i=1:
  - count->0, state->ACCUM, stage-1/2 valid cleared, acc_clear_o=1 next cycle.
  - FIFO contents are preserved.
  - Has priority over a simultaneous capture.
- Reset mid-frame discards everything, including the FIFO.
- ACC_LEN=1: every p_valid_i outside CLEAR triggers a capture.

Decomposition:
- Package dsp_accum_pkg: the FSM state enum (ACCUM, CLEAR) and a function round_shift_sat(value, SHIFT, OUT_W) returning {sat, data}. The bench reuses this function for its model.
- Sub-module dsp_out_fifo: synchronous FIFO parameterised by width and depth, with push/pop/full/empty.

Test Plan:
- ACC_LEN=4, SHIFT=4. Valid p_i = 10, 20, 30, 40 -> capture 40; acc_clear_o high the next cycle; out_data_o=3 ((40+8)>>4), out_sat_o=0, valid 2 cycles after capture.
- Same configuration, final p_i = -40 -> out_data_o=-2; final p_i = -8 -> 0 (round half up).
- Final p_i = 2^25 -> out_data_o=32767, out_sat_o=1; final p_i = -2^25 -> -32768, out_sat_o=1.
- out_ready_i=0 for three frames -> two entries held, third dropped, overflow_o=1. Release ready -> two pops in order. clr_ovf_i -> overflow_o=0.
- Drop reset to 0 after 2 of 4 steps -> all outputs at reset values, count_o=0. After release, a full 4-step frame produces the correct single result.
- soft_clear_i asserted on the same cycle as the 4th valid -> no capture, acc_clear_o pulse, count_o=0, FIFO unchanged; the next frame is correct.

Source files
------------

// File: rtl/dsp_accum_pkg.sv
// Shared types and arithmetic helpers for the accumulate/dump/round/saturate stage.
package dsp_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // data is the sign-extended result; callers keep the low OUT_W bits
  typedef struct packed {
    logic        sat;
    logic [63:0] data;
  } rss_t;

  // Round half up (when shift > 0), then arithmetic shift right
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                    input int shift);
    logic signed [63:0] r;
    r = value;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    return r >>> shift;
  endfunction

  // Clamp to the signed out_w-bit range and flag when clamping happened
  function automatic rss_t saturate(input logic signed [63:0] value, input int out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rss_t res;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      res.sat  = 1'b1;
      res.data = max_v;
    end else if (value < min_v) begin
      res.sat  = 1'b1;
      res.data = min_v;
    end else begin
      res.sat  = 1'b0;
      res.data = value;
    end
    return res;
  endfunction

  function automatic rss_t round_shift_sat(input logic signed [63:0] value,
                                           input int shift, input int out_w);
    return saturate(round_shift(value, shift), out_w);
  endfunction

endpackage

// File: rtl/dsp_accum_dump_round_sat_fifo.sv
// Small synchronous FIFO for finished output samples. A push while full is
// only taken when a pop happens in the same cycle; no empty-FIFO bypass.
module dsp_out_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; wrap bit distinguishes full from empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage; contents are only observed while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/dsp_accum_dump_round_sat.sv
// Counts MAC accumulation steps, dumps the accumulator every ACC_LEN steps,
// requests a MAC clear, and emits a rounded/shifted/saturated sample via a FIFO.
//   state | meaning
//   ACCUM | counting valid accumulation steps
//   CLEAR | MAC accumulator being cleared; p_valid_i ignored
module dsp_accum_dump_round_sat
  import dsp_accum_pkg::*;
#(
  parameter int IN_W       = 38,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 12,
  parameter int ACC_LEN    = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [IN_W-1:0]             p_i,
  input  logic                               p_valid_i,
  input  logic                               soft_clear_i,
  output logic                               acc_clear_o,
  output logic signed [OUT_W-1:0]            out_data_o,
  output logic                               out_sat_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               overflow_o,
  input  logic                               clr_ovf_i,
  output logic [$clog2(ACC_LEN+1)-1:0]       count_o
);

  localparam int              CNT_W = $clog2(ACC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_acc_clear;
  logic               r_s1_valid;
  logic [IN_W:0]      r_s1_val;
  logic               r_ovf;
  logic [OUT_W-1:0]   r_last_data;
  logic               r_last_sat;

  logic               w_capture;
  logic signed [63:0] w_p_ext;
  logic signed [63:0] w_rs;
  logic signed [63:0] w_s1_ext;
  rss_t               w_sat_res;
  logic               w_push;
  logic               w_pop;
  logic [OUT_W:0]     w_fifo_in;
  logic [OUT_W:0]     w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_unused_bits;

  assign w_capture = (r_state == ACCUM) & p_valid_i & (r_count == LAST) & ~soft_clear_i;
  assign w_p_ext   = {{(64-IN_W){p_i[IN_W-1]}}, p_i};
  assign w_rs      = round_shift(w_p_ext, SHIFT);
  assign w_s1_ext  = {{(63-IN_W){r_s1_val[IN_W]}}, r_s1_val};
  assign w_sat_res = saturate(w_s1_ext, OUT_W);
  // A soft clear in the stage-2 cycle discards the in-flight result
  assign w_push    = r_s1_valid & ~soft_clear_i;
  assign w_pop     = ~w_empty & out_ready_i;
  assign w_fifo_in = {w_sat_res.sat, w_sat_res.data[OUT_W-1:0]};
  assign w_unused_bits = ^{w_rs[63:IN_W+1], w_sat_res.data[63:OUT_W]};

  // Frame FSM: step counting, dump capture and the registered clear request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ACCUM;
      r_count     <= '0;
      r_acc_clear <= 1'b0;
    end else begin
      r_acc_clear <= w_capture | soft_clear_i;
      if (soft_clear_i) begin
        r_state <= ACCUM;
        r_count <= '0;
      end else begin
        case (r_state)
          ACCUM: begin
            if (p_valid_i) begin
              if (r_count == LAST) begin
                r_count <= '0;
                r_state <= CLEAR;
              end else begin
                r_count <= r_count + CNT_W'(1);
              end
            end
          end
          CLEAR:   r_state <= ACCUM;
          default: r_state <= ACCUM;
        endcase
      end
    end
  end

  // Stage 1: round and shift the captured accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_val   <= '0;
    end else begin
      r_s1_valid <= w_capture;
      if (w_capture) r_s1_val <= w_rs[IN_W:0];
    end
  end

  // Sticky overflow: a stage-2 result lost to a full FIFO; set beats clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_push & w_full & ~w_pop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf_i) begin
      r_ovf <= 1'b0;
    end
  end

  // Remember the last presented head so outputs hold while the FIFO is empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_data <= '0;
      r_last_sat  <= 1'b0;
    end else if (w_pop) begin
      r_last_data <= w_head[OUT_W-1:0];
      r_last_sat  <= w_head[OUT_W];
    end
  end

  dsp_out_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_fifo_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign acc_clear_o = r_acc_clear;
  assign out_valid_o = ~w_empty;
  assign out_data_o  = w_empty ? r_last_data : w_head[OUT_W-1:0];
  assign out_sat_o   = w_empty ? r_last_sat  : w_head[OUT_W];
  assign overflow_o  = r_ovf;
  assign count_o     = r_count;

endmodule

// File: tb/tb_dsp_accum_dump_round_sat.sv
// Bench for dsp_accum_dump_round_sat: spec-level model with per-cycle compare
// plus hand-computed expectations for the directed frames.
module tb_dsp_accum_dump_round_sat;
  import dsp_accum_pkg::*;

  localparam int IN_W       = 38;
  localparam int OUT_W      = 16;
  localparam int SHIFT      = 4;
  localparam int ACC_LEN    = 4;
  localparam int FIFO_DEPTH = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic signed [IN_W-1:0]  p_i = '0;
  logic                    p_valid_i = 1'b0;
  logic                    soft_clear_i = 1'b0;
  logic                    acc_clear_o;
  logic signed [OUT_W-1:0] out_data_o;
  logic                    out_sat_o;
  logic                    out_valid_o;
  logic                    out_ready_i = 1'b1;
  logic                    overflow_o;
  logic                    clr_ovf_i = 1'b0;
  logic [2:0]              count_o;

  int errors = 0;
  int checks = 0;

  dsp_accum_dump_round_sat #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ACC_LEN(ACC_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .p_i(p_i), .p_valid_i(p_valid_i),
    .soft_clear_i(soft_clear_i), .acc_clear_o(acc_clear_o), .out_data_o(out_data_o),
    .out_sat_o(out_sat_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic             sat;
    logic [OUT_W-1:0] data;
  } ent_t;

  ent_t             m_fifo[$];
  int               m_count;
  bit               m_clear;
  bit               m_acc_clear;
  bit               m_s1_valid;
  longint           m_s1_p;
  logic [OUT_W-1:0] m_last_data;
  logic             m_last_sat;
  bit               m_ovf;

  always @(posedge clk or negedge reset) begin
    rss_t res;
    ent_t e;
    bit   pop;
    bit   cap;
    bit   set_ovf;
    if (!reset) begin
      m_fifo.delete();
      m_count = 0; m_clear = 0; m_acc_clear = 0; m_s1_valid = 0; m_s1_p = 0;
      m_last_data = '0; m_last_sat = 1'b0; m_ovf = 0;
    end else begin
      pop     = (m_fifo.size() > 0) && out_ready_i;
      set_ovf = 0;
      if (pop) begin
        e = m_fifo.pop_front();
        m_last_data = e.data;
        m_last_sat  = e.sat;
      end
      if (m_s1_valid && !soft_clear_i) begin
        res    = round_shift_sat(m_s1_p, SHIFT, OUT_W);
        e.sat  = res.sat;
        e.data = res.data[OUT_W-1:0];
        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(e);
        else set_ovf = 1;
      end
      if (set_ovf) m_ovf = 1;
      else if (clr_ovf_i) m_ovf = 0;
      cap = !m_clear && p_valid_i && (m_count == ACC_LEN - 1) && !soft_clear_i;
      m_acc_clear = cap || soft_clear_i;
      m_s1_valid  = cap;
      if (cap) m_s1_p = longint'(p_i);
      if (soft_clear_i) begin
        m_count = 0; m_clear = 0;
      end else if (m_clear) begin
        m_clear = 0;
      end else if (p_valid_i) begin
        if (cap) begin m_count = 0; m_clear = 1; end
        else m_count = m_count + 1;
      end
    end
  end

  // Compare every cycle while out of reset
  always @(negedge clk) begin
    logic [OUT_W-1:0] ed;
    logic             es;
    if (reset) begin
      ed = (m_fifo.size() > 0) ? m_fifo[0].data : m_last_data;
      es = (m_fifo.size() > 0) ? m_fifo[0].sat  : m_last_sat;
      check("acc_clear", acc_clear_o, m_acc_clear);
      check("out_valid", out_valid_o, (m_fifo.size() > 0));
      check("out_data", out_data_o, longint'($signed(ed)));
      check("out_sat", out_sat_o, es);
      check("overflow", overflow_o, m_ovf);
      check("count", count_o, m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input longint v);
    p_i = IN_W'(v);
    p_valid_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
  endtask

  task automatic frame(input longint a, input longint b, input longint c, input longint d);
    send(a); send(b); send(c); send(d);
  endtask

  // Full frame with an empty, ready FIFO: check clear pulse and 2-cycle latency
  task automatic frame_check(input string nm, input longint a, input longint b,
                             input longint c, input longint d,
                             input longint exp_data, input longint exp_sat);
    frame(a, b, c, d);
    @(negedge clk);
    check({nm, "_clr_pulse"}, acc_clear_o, 1);
    check({nm, "_not_yet_valid"}, out_valid_o, 0);
    tick();
    @(negedge clk);
    check({nm, "_valid"}, out_valid_o, 1);
    check({nm, "_data"}, out_data_o, exp_data);
    check({nm, "_sat"}, out_sat_o, exp_sat);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_acc_clear", acc_clear_o, 0);
    check("rst_count", count_o, 0);
    reset = 1'b1;
    tick();

    frame_check("f40", 10, 20, 30, 40, 3, 0);
    frame_check("fm40", 1, 2, 3, -40, -2, 0);
    frame_check("fm8", 1, 2, 3, -8, 0, 0);
    frame_check("fpos_sat", 1, 2, 3, 64'sd1 <<< 25, 32767, 1);
    frame_check("fneg_sat", 1, 2, 3, -(64'sd1 <<< 25), -32768, 1);

    // Back-pressure: three frames, two stored, third dropped
    out_ready_i = 1'b0;
    frame(1, 1, 1, 160); tick();
    frame(1, 1, 1, 320); tick();
    frame(1, 1, 1, 480); tick(); tick();
    @(negedge clk);
    check("ovf_set", overflow_o, 1);
    check("ovf_head", out_data_o, 10);
    out_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("pop1_next", out_data_o, 20);
    tick();
    @(negedge clk);
    check("pop2_empty", out_valid_o, 0);
    check("pop2_hold", out_data_o, 20);
    check("ovf_sticky", overflow_o, 1);
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    @(negedge clk);
    check("ovf_cleared", overflow_o, 0);

    // Reset mid-frame with a stored entry
    out_ready_i = 1'b0;
    frame(1, 1, 1, 160); tick(); tick();
    send(1); send(1);
    @(negedge clk);
    check("pre_rst_count", count_o, 2);
    check("pre_rst_valid", out_valid_o, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_data", out_data_o, 0);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_ovf", overflow_o, 0);
    tick();
    reset = 1'b1;
    out_ready_i = 1'b1;
    tick();
    frame_check("post_rst", 10, 20, 30, 40, 3, 0);

    // Soft clear on the 4th valid: no capture, FIFO kept
    out_ready_i = 1'b0;
    frame(1, 1, 1, 320); tick(); tick();
    send(1); send(1); send(1);
    p_i = IN_W'(999);
    p_valid_i = 1'b1;
    soft_clear_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
    soft_clear_i = 1'b0;
    @(negedge clk);
    check("sc_clr_pulse", acc_clear_o, 1);
    check("sc_count", count_o, 0);
    check("sc_head", out_data_o, 20);
    tick(); tick(); tick();
    out_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("sc_single_entry", out_valid_o, 0);
    frame_check("post_sc", 1, 2, 3, -40, -2, 0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
